// File: rtl/uart_tx_fsm.sv
// Frame sequencer for the UART transmitter: start, DATA_WIDTH data bits,
// optional parity, stop. Drives the TX mux select and serializer enables.
// Optional build macro: UART_TX_TWO_STOP_EN (two stop-bit cycles per frame).
module uart_tx_fsm #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DATA_VALID,
  input  logic       PAR_EN,
  output logic [1:0] MUX_SEL,
  output logic       SER_LOAD,
  output logic       SER_EN,
  output logic       BUSY,
  output logic       FRAME_DONE
);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_STOP   = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             last_stop;
  logic             accept;

`ifdef UART_TX_TWO_STOP_EN
  logic stop_q, stop_d;

  // Second stop cycle is the only one that ends the frame.
  assign last_stop = (state_q == S_STOP) && stop_q;

  // Stop-bit counter register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) stop_q <= 1'b0;
    else      stop_q <= stop_d;
  end
`else
  assign last_stop = (state_q == S_STOP);
`endif

  // Request is taken when idle or in the final stop cycle; gated off during reset.
  assign accept   = RST && DATA_VALID && ((state_q == S_IDLE) || last_stop);
  assign SER_LOAD = accept;

  // State, data-bit counter and latched parity enable.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    par_d      = par_q;
`ifdef UART_TX_TWO_STOP_EN
    stop_d     = stop_q;
`endif
    MUX_SEL    = SEL_STOP;
    SER_EN     = 1'b0;
    BUSY       = 1'b0;
    FRAME_DONE = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          par_d   = PAR_EN;
        end
      end
      S_START: begin
        MUX_SEL = SEL_START;
        BUSY    = 1'b1;
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        MUX_SEL = SEL_DATA;
        SER_EN  = 1'b1;
        BUSY    = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = par_q ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        MUX_SEL = SEL_PARITY;
        BUSY    = 1'b1;
        state_d = S_STOP;
      end
      S_STOP: begin
        MUX_SEL    = SEL_STOP;
        BUSY       = 1'b1;
        FRAME_DONE = last_stop;
`ifdef UART_TX_TWO_STOP_EN
        if (!stop_q) begin
          stop_d = 1'b1;
        end else begin
          stop_d = 1'b0;
`endif
          if (accept) begin
            state_d = S_START;
            par_d   = PAR_EN;
          end else begin
            state_d = S_IDLE;
          end
`ifdef UART_TX_TWO_STOP_EN
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        par_d   = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        stop_d  = 1'b0;
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Scoreboard bench for uart_tx_fsm: a frame-level model queues expected
// per-cycle outputs; a negedge monitor pops and compares.
module tb_uart_tx_fsm;

  localparam int unsigned DW = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int unsigned NSTOP = 2;
`else
  localparam int unsigned NSTOP = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic [1:0] MUX_SEL;
  logic       SER_LOAD, SER_EN, BUSY, FRAME_DONE;

  typedef struct packed {
    logic [1:0] mux;
    logic       ser_en;
    logic       busy;
    logic       frame_done;
    logic       ser_load;
  } vec_t;

  localparam vec_t IDLE_V = '{mux: 2'b01, ser_en: 1'b0, busy: 1'b0, frame_done: 1'b0, ser_load: 1'b0};

  vec_t frame_q[$];   // model: remaining cycles of the frame in flight
  vec_t sb_q[$];      // scoreboard: expected outputs per cycle
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  uart_tx_fsm #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .DATA_VALID(DATA_VALID), .PAR_EN(PAR_EN),
    .MUX_SEL(MUX_SEL), .SER_LOAD(SER_LOAD), .SER_EN(SER_EN),
    .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  // Append one frame's worth of expected cycles to the model.
  task automatic push_frame(input logic pe);
    vec_t v;
    v = '{mux: 2'b00, ser_en: 1'b0, busy: 1'b1, frame_done: 1'b0, ser_load: 1'b0};
    frame_q.push_back(v);
    for (int i = 0; i < int'(DW); i++) begin
      v = '{mux: 2'b10, ser_en: 1'b1, busy: 1'b1, frame_done: 1'b0, ser_load: 1'b0};
      frame_q.push_back(v);
    end
    if (pe) begin
      v = '{mux: 2'b11, ser_en: 1'b0, busy: 1'b1, frame_done: 1'b0, ser_load: 1'b0};
      frame_q.push_back(v);
    end
    for (int i = 0; i < int'(NSTOP); i++) begin
      v = '{mux: 2'b01, ser_en: 1'b0, busy: 1'b1,
            frame_done: (i == int'(NSTOP) - 1), ser_load: 1'b0};
      frame_q.push_back(v);
    end
  endtask

  // Drive one cycle of stimulus and queue the expected response.
  task automatic step(input logic dv, input logic pe, input logic rn);
    vec_t cur;
    bit   idle, acc;
    @(posedge CLK);
    #1;
    RST = rn; DATA_VALID = dv; PAR_EN = pe;
    if (!rn) begin
      frame_q.delete();
      cur = IDLE_V;
    end else begin
      idle = (frame_q.size() == 0);
      cur  = idle ? IDLE_V : frame_q.pop_front();
      acc  = dv && (idle || cur.frame_done);
      cur.ser_load = acc;
      if (acc) push_frame(pe);
    end
    sb_q.push_back(cur);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the scoreboard head.
  initial begin
    vec_t exp_v, act_v;
    forever begin
      @(negedge CLK);
      cyc++;
      if (sb_q.size() != 0) begin
        exp_v = sb_q.pop_front();
        act_v = '{mux: MUX_SEL, ser_en: SER_EN, busy: BUSY, frame_done: FRAME_DONE, ser_load: SER_LOAD};
        n_vec++;
        if (act_v !== exp_v) begin
          n_err++;
          $display("FAIL outputs cyc=%0d got mux=%b en=%b busy=%b done=%b load=%b want mux=%b en=%b busy=%b done=%b load=%b",
                   cyc, act_v.mux, act_v.ser_en, act_v.busy, act_v.frame_done, act_v.ser_load,
                   exp_v.mux, exp_v.ser_en, exp_v.busy, exp_v.frame_done, exp_v.ser_load);
        end
      end
    end
  end

  initial begin
    // Reset held with a pending request, then release with it still high.
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    repeat (14) step(1'b0, 1'b0, 1'b1);

    // Single frame, no parity.
    step(1'b1, 1'b0, 1'b1);
    repeat (13) step(1'b0, 1'b0, 1'b1);

    // Parity frame, PAR_EN dropped mid-frame; DATA_VALID pokes while busy.
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b0, 1'b1);

    // Back-to-back frames with DATA_VALID held high.
    repeat (40) step(1'b1, 1'b0, 1'b1);
    repeat (14) step(1'b0, 1'b0, 1'b1);

    // Abort mid-frame, then a full frame.
    step(1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    repeat (14) step(1'b0, 1'b0, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      logic dv, pe, rn;
      dv = ($urandom_range(0, 3) == 0) || (i % 300 < 30);
      pe = 1'($urandom_range(0, 1));
      rn = ($urandom_range(0, 199) != 0);
      step(dv, pe, rn);
    end
    repeat (20) step(1'b0, 1'b0, 1'b1);

    @(posedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain leftover=%0d want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
